// File: rtl/axis_snapshot_packer_pkg.sv
// Shared types and constants for the snapshot packer.
// Header layout: {magic, mask, zero-extended seq} from MSB down.
package axis_snapshot_packer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HEADER,
      DATA
   } state_e;

   localparam logic [7:0] HDR_MAGIC = 8'hA5;
   localparam int NCH_MAX     = 8;
   localparam int IDX_W       = 3;

   // Field widths; magic sits at the top, mask below it, seq at bit 0
   localparam int HDR_MAGIC_W = 8;
   localparam int HDR_MASK_W  = 8;
   localparam int HDR_SEQ_LSB = 0;

endpackage

// File: rtl/axis_snapshot_packer_mask_next_index.sv
// Finds the next enabled channel in the latched mask.
// first_i searches from channel 0, otherwise strictly above cur_i.
module mask_next_index
   import axis_snapshot_packer_pkg::*;
(
   input  logic [NCH_MAX-1:0] mask_i,
   input  logic [IDX_W-1:0]   cur_i,
   input  logic               first_i,
   output logic [IDX_W-1:0]   next_o,
   output logic               last_o
);

   logic found;

   // Lowest qualifying set bit, then whether any set bit lies above it
   always_comb begin
      next_o = '0;
      found  = 1'b0;
      last_o = 1'b1;
      for (int i = 0; i < NCH_MAX; i++) begin
         if (!found && mask_i[i] && (first_i || i > int'(cur_i))) begin
            next_o = IDX_W'(i);
            found  = 1'b1;
         end
      end
      for (int i = 0; i < NCH_MAX; i++) begin
         if (mask_i[i] && i > int'(next_o)) last_o = 1'b0;
      end
   end

endmodule

// File: rtl/axis_snapshot_packer.sv
// Snapshots up to six tvalid-only channels on a strobe and
// emits them as a framed AXIS packet behind a header word.
module axis_snapshot_packer
   import axis_snapshot_packer_pkg::*;
#(
   parameter int NCH        = 6,
   parameter int DATA_WIDTH = 32,
   parameter int SEQ_WIDTH  = 16
) (
   input  logic                  a_clk,
   input  logic                  a_resetn,
   input  logic [DATA_WIDTH-1:0] S_AXIS_1_tdata,
   input  logic                  S_AXIS_1_tvalid,
   input  logic [DATA_WIDTH-1:0] S_AXIS_2_tdata,
   input  logic                  S_AXIS_2_tvalid,
   input  logic [DATA_WIDTH-1:0] S_AXIS_3_tdata,
   input  logic                  S_AXIS_3_tvalid,
   input  logic [DATA_WIDTH-1:0] S_AXIS_4_tdata,
   input  logic                  S_AXIS_4_tvalid,
   input  logic [DATA_WIDTH-1:0] S_AXIS_5_tdata,
   input  logic                  S_AXIS_5_tvalid,
   input  logic [DATA_WIDTH-1:0] S_AXIS_6_tdata,
   input  logic                  S_AXIS_6_tvalid,
   input  logic                  sample_strobe,
   input  logic                  enable,
   input  logic [NCH-1:0]        channel_mask,
   output logic [DATA_WIDTH-1:0] M_AXIS_tdata,
   output logic                  M_AXIS_tvalid,
   input  logic                  M_AXIS_tready,
   output logic                  M_AXIS_tlast,
   output logic                  busy,
   output logic [15:0]           overrun_count
);

   localparam int SEQ_EXT_W = DATA_WIDTH - HDR_MAGIC_W - HDR_MASK_W;

   logic [DATA_WIDTH-1:0] in_data [NCH_MAX];
   logic [NCH_MAX-1:0]    in_vld;
   logic [DATA_WIDTH-1:0] hold_q  [NCH_MAX];
   logic [DATA_WIDTH-1:0] snap_q  [NCH_MAX];
   logic [NCH_MAX-1:0]    mask_q, mask_in;
   logic [SEQ_WIDTH-1:0]  seq_q;
   logic [15:0]           ovr_q;
   state_e                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d, nxt_idx;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d, hdr_word;
   logic                  tvalid_q, tvalid_d;
   logic                  tlast_q, tlast_d;
   logic                  nxt_last, hs, fin_hs, accept, drop;

   // Channels 7..8 have no port; mask bits above NCH are dropped
   assign in_data[0] = S_AXIS_1_tdata;
   assign in_data[1] = S_AXIS_2_tdata;
   assign in_data[2] = S_AXIS_3_tdata;
   assign in_data[3] = S_AXIS_4_tdata;
   assign in_data[4] = S_AXIS_5_tdata;
   assign in_data[5] = S_AXIS_6_tdata;
   assign in_data[6] = '0;
   assign in_data[7] = '0;
   assign in_vld = {2'b00, S_AXIS_6_tvalid, S_AXIS_5_tvalid,
                    S_AXIS_4_tvalid, S_AXIS_3_tvalid,
                    S_AXIS_2_tvalid, S_AXIS_1_tvalid};
   assign mask_in = NCH_MAX'(channel_mask);

   assign hs     = tvalid_q & M_AXIS_tready;
   assign fin_hs = hs & tlast_q;
   assign accept = sample_strobe & enable &
                   ((state_q == IDLE) | fin_hs);
   assign drop   = sample_strobe & enable & ~accept;

   // Header is built from live mask and current seq at accept time
   assign hdr_word = {HDR_MAGIC, mask_in,
                      SEQ_EXT_W'(seq_q) << HDR_SEQ_LSB};

   mask_next_index u_nxt (
      .mask_i  (mask_q),
      .cur_i   (idx_q),
      .first_i (state_q == HEADER),
      .next_o  (nxt_idx),
      .last_o  (nxt_last)
   );

   // FSM state register
   always_ff @(posedge a_clk or negedge a_resetn) begin
      if (!a_resetn) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // FSM next state; back-to-back accept re-enters HEADER directly
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = HEADER;
         HEADER, DATA: begin
            if (hs) begin
               if (tlast_q) state_d = accept ? HEADER : IDLE;
               else         state_d = DATA;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Next output beat; held unchanged while stalled
   always_comb begin
      tdata_d  = tdata_q;
      tlast_d  = tlast_q;
      tvalid_d = tvalid_q;
      idx_d    = idx_q;
      if (accept) begin
         tdata_d  = hdr_word;
         tlast_d  = (mask_in == '0);
         tvalid_d = 1'b1;
         idx_d    = '0;
      end else if (hs) begin
         if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
         end else begin
            idx_d   = nxt_idx;
            tdata_d = snap_q[nxt_idx];
            tlast_d = nxt_last;
         end
      end
   end

   // Registered output beat and channel cursor
   always_ff @(posedge a_clk or negedge a_resetn) begin
      if (!a_resetn) begin
         tdata_q  <= '0;
         tlast_q  <= 1'b0;
         tvalid_q <= 1'b0;
         idx_q    <= '0;
      end else begin
         tdata_q  <= tdata_d;
         tlast_q  <= tlast_d;
         tvalid_q <= tvalid_d;
         idx_q    <= idx_d;
      end
   end

   // Hold/snapshot capture, frame latches, seq and overrun counters
   always_ff @(posedge a_clk or negedge a_resetn) begin
      if (!a_resetn) begin
         for (int i = 0; i < NCH_MAX; i++) begin
            hold_q[i] <= '0;
            snap_q[i] <= '0;
         end
         mask_q <= '0;
         seq_q  <= '0;
         ovr_q  <= '0;
      end else begin
         for (int i = 0; i < NCH_MAX; i++) begin
            if (in_vld[i]) hold_q[i] <= in_data[i];
            if (accept)
               snap_q[i] <= in_vld[i] ? in_data[i] : hold_q[i];
         end
         if (accept) begin
            mask_q <= mask_in;
            seq_q  <= seq_q + SEQ_WIDTH'(1);
         end
         if (drop && ovr_q != 16'hFFFF) ovr_q <= ovr_q + 16'd1;
      end
   end

   assign M_AXIS_tdata  = tdata_q;
   assign M_AXIS_tvalid = tvalid_q;
   assign M_AXIS_tlast  = tlast_q;
   assign busy          = (state_q != IDLE);
   assign overrun_count = ovr_q;

endmodule

// File: tb/tb_axis_snapshot_packer.sv
// Directed bench for axis_snapshot_packer with a beat scoreboard.
module tb_axis_snapshot_packer;

   logic        clk = 1'b0;
   logic        a_resetn;
   logic [31:0] dat [6];
   logic [5:0]  vld;
   logic        sample_strobe, enable;
   logic [5:0]  channel_mask;
   logic [31:0] M_AXIS_tdata;
   logic        M_AXIS_tvalid, M_AXIS_tready, M_AXIS_tlast;
   logic        busy;
   logic [15:0] overrun_count;

   logic        rdy_fix, rand_rdy, rnd;
   logic [31:0] hm [6];
   logic [32:0] q [$];
   logic [15:0] exp_seq;
   logic [31:0] exp_h;
   int          checks = 0;
   int          errors = 0;

   logic        prev_stall;
   logic [31:0] prev_d;
   logic        prev_l;

   always #5 clk = ~clk;

   assign M_AXIS_tready = rand_rdy ? rnd : rdy_fix;

   always @(posedge clk) begin
      #1 rnd = 1'($urandom_range(0, 1));
   end

   axis_snapshot_packer dut (
      .a_clk           (clk),
      .a_resetn        (a_resetn),
      .S_AXIS_1_tdata  (dat[0]),
      .S_AXIS_1_tvalid (vld[0]),
      .S_AXIS_2_tdata  (dat[1]),
      .S_AXIS_2_tvalid (vld[1]),
      .S_AXIS_3_tdata  (dat[2]),
      .S_AXIS_3_tvalid (vld[2]),
      .S_AXIS_4_tdata  (dat[3]),
      .S_AXIS_4_tvalid (vld[3]),
      .S_AXIS_5_tdata  (dat[4]),
      .S_AXIS_5_tvalid (vld[4]),
      .S_AXIS_6_tdata  (dat[5]),
      .S_AXIS_6_tvalid (vld[5]),
      .sample_strobe   (sample_strobe),
      .enable          (enable),
      .channel_mask    (channel_mask),
      .M_AXIS_tdata    (M_AXIS_tdata),
      .M_AXIS_tvalid   (M_AXIS_tvalid),
      .M_AXIS_tready   (M_AXIS_tready),
      .M_AXIS_tlast    (M_AXIS_tlast),
      .busy            (busy),
      .overrun_count   (overrun_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One cycle; hold model tracks valid words seen at the edge
   task automatic clk1();
      @(posedge clk);
      for (int i = 0; i < 6; i++)
         if (vld[i] && a_resetn) hm[i] = dat[i];
      #1;
   endtask

   function automatic logic [31:0] hdr(input logic [5:0] m,
                                       input logic [15:0] s);
      return {8'hA5, 2'b00, m, s};
   endfunction

   // Expected frame from the current inputs and hold model
   task automatic push_frame(input logic [5:0] m);
      logic [31:0] w;
      q.push_back({(m == 6'd0), hdr(m, exp_seq)});
      for (int i = 0; i < 6; i++) begin
         if (m[i]) begin
            w = vld[i] ? dat[i] : hm[i];
            q.push_back({((m >> (i + 1)) == 6'd0), w});
         end
      end
      exp_seq++;
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      while ((q.size() != 0 || busy) && n < bound) begin
         clk1();
         n++;
      end
      chk("drain_left", q.size(), 0);
      chk("drain_busy", {31'd0, busy}, 0);
   endtask

   // Scoreboard pop on handshake and stall-stability checks
   always @(negedge clk) begin
      logic [32:0] e;
      if (!a_resetn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_v", {31'd0, M_AXIS_tvalid}, 1);
            chk("stall_d", M_AXIS_tdata, prev_d);
            chk("stall_l", {31'd0, M_AXIS_tlast}, {31'd0, prev_l});
         end
         if (M_AXIS_tvalid && M_AXIS_tready) begin
            chk("beat_avail", {31'd0, q.size() > 0}, 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("beat_d", M_AXIS_tdata, e[31:0]);
               chk("beat_l", {31'd0, M_AXIS_tlast}, {31'd0, e[32]});
            end
         end
         prev_stall = M_AXIS_tvalid && !M_AXIS_tready;
         prev_d     = M_AXIS_tdata;
         prev_l     = M_AXIS_tlast;
      end
   end

   initial begin
      a_resetn = 1'b0;
      for (int i = 0; i < 6; i++) begin
         dat[i] = '0;
         hm[i]  = '0;
      end
      vld = '0;
      sample_strobe = 1'b0;
      enable = 1'b0;
      channel_mask = '0;
      rdy_fix = 1'b0;
      rand_rdy = 1'b0;
      rnd = 1'b0;
      exp_seq = '0;
      prev_stall = 1'b0;
      repeat (3) clk1();
      chk("rst_tvalid", {31'd0, M_AXIS_tvalid}, 0);
      chk("rst_tlast", {31'd0, M_AXIS_tlast}, 0);
      chk("rst_tdata", M_AXIS_tdata, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_ovr", {16'd0, overrun_count}, 0);
      a_resetn = 1'b1;
      clk1();
      enable = 1'b1;

      // Two-channel frame, continuous ready
      dat[0] = 32'h11; vld[0] = 1'b1;
      dat[2] = 32'h33; vld[2] = 1'b1;
      channel_mask = 6'b000101;
      rdy_fix = 1'b1;
      sample_strobe = 1'b1;
      push_frame(channel_mask);
      clk1();
      sample_strobe = 1'b0;
      vld = '0;
      chk("lat_tvalid", {31'd0, M_AXIS_tvalid}, 1);
      chk("lat_busy", {31'd0, busy}, 1);
      chk("hdr1", M_AXIS_tdata, 32'hA505_0000);
      drain(50);

      // Empty-mask frames: header only, tlast set
      channel_mask = '0;
      for (int k = 0; k < 2; k++) begin
         sample_strobe = 1'b1;
         push_frame(channel_mask);
         clk1();
         sample_strobe = 1'b0;
         chk("m0_tlast", {31'd0, M_AXIS_tlast}, 1);
         drain(20);
         clk1();
      end

      // All channels, random ready
      for (int i = 0; i < 6; i++) dat[i] = 32'h1000 + i;
      vld = 6'h3F;
      channel_mask = 6'h3F;
      rand_rdy = 1'b1;
      sample_strobe = 1'b1;
      push_frame(channel_mask);
      clk1();
      sample_strobe = 1'b0;
      vld = '0;
      drain(300);
      rand_rdy = 1'b0;

      // Strobe while stalled in DATA is dropped; inputs change mid-frame
      rdy_fix = 1'b0;
      sample_strobe = 1'b1;
      push_frame(channel_mask);
      clk1();
      sample_strobe = 1'b0;
      rdy_fix = 1'b1;
      clk1();
      rdy_fix = 1'b0;
      clk1();
      chk("stall_busy", {31'd0, busy}, 1);
      channel_mask = 6'h01;
      dat[0] = 32'hDEAD; vld[0] = 1'b1;
      sample_strobe = 1'b1;
      clk1();
      sample_strobe = 1'b0;
      vld = '0;
      chk("ovr_one", {16'd0, overrun_count}, 1);
      enable = 1'b0;
      sample_strobe = 1'b1;
      clk1();
      sample_strobe = 1'b0;
      enable = 1'b1;
      chk("ovr_disabled", {16'd0, overrun_count}, 1);
      rdy_fix = 1'b1;
      drain(50);

      // Strobe landing on the final handshake
      channel_mask = 6'b000010;
      dat[1] = 32'h22; vld[1] = 1'b1;
      sample_strobe = 1'b1;
      push_frame(channel_mask);
      clk1();
      sample_strobe = 1'b0;
      vld = '0;
      clk1();
      sample_strobe = 1'b1;
      exp_h = hdr(channel_mask, exp_seq);
      push_frame(channel_mask);
      clk1();
      sample_strobe = 1'b0;
      chk("b2b_tvalid", {31'd0, M_AXIS_tvalid}, 1);
      chk("b2b_hdr", M_AXIS_tdata, exp_h);
      chk("b2b_ovr", {16'd0, overrun_count}, 1);
      drain(50);

      // Word valid on the strobe cycle wins over the hold value
      dat[1] = 32'h1; vld[1] = 1'b1;
      clk1();
      vld = '0;
      clk1();
      dat[1] = 32'hBEEF; vld[1] = 1'b1;
      sample_strobe = 1'b1;
      push_frame(channel_mask);
      clk1();
      sample_strobe = 1'b0;
      vld = '0;
      dat[1] = 32'h5555;
      clk1();
      chk("beef", M_AXIS_tdata, 32'hBEEF);
      drain(50);

      // Async reset mid-frame, then seq restarts at zero
      channel_mask = 6'h3F;
      rdy_fix = 1'b0;
      sample_strobe = 1'b1;
      push_frame(channel_mask);
      clk1();
      sample_strobe = 1'b0;
      clk1();
      a_resetn = 1'b0;
      #1;
      chk("arst_tvalid", {31'd0, M_AXIS_tvalid}, 0);
      chk("arst_tlast", {31'd0, M_AXIS_tlast}, 0);
      chk("arst_busy", {31'd0, busy}, 0);
      chk("arst_ovr", {16'd0, overrun_count}, 0);
      q.delete();
      exp_seq = '0;
      for (int i = 0; i < 6; i++) hm[i] = '0;
      clk1();
      clk1();
      a_resetn = 1'b1;
      clk1();
      channel_mask = 6'h01;
      rdy_fix = 1'b1;
      sample_strobe = 1'b1;
      push_frame(channel_mask);
      clk1();
      sample_strobe = 1'b0;
      chk("rst_seq0", M_AXIS_tdata, 32'hA501_0000);
      drain(50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
